// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master transfer sequencer: chip select, gated SCLK divider, and DATA_W-bit full-duplex shift.
// Define SPI_LSB_FIRST_EN to add the lsb_first port, which selects bit order per transfer.
module spi_xfer_ctrl #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 5,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clkin,
    input  logic              reset,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TCNT_W  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [TCNT_W-1:0] SETUP_LAST = TCNT_W'(CS_SETUP - 1);
    localparam logic [TCNT_W-1:0] HOLD_LAST  = TCNT_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                lsb_q, lsb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                tick;
    logic                lsb_start;
    logic [DATA_W-1:0]   tx_shift;
    logic [DATA_W-1:0]   rx_shift;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_start = lsb_first;
`else
    assign lsb_start = 1'b0;
`endif

    // The divider only runs while a transfer is in flight, so SETUP starts a full tick after acceptance.
    assign tick = (state_q != IDLE) && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (state_q == IDLE || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        tx_shift = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        rx_shift = lsb_q ? ((rx_q >> 1) | (DATA_W'(miso) << (DATA_W - 1)))
                         : ((rx_q << 1) | DATA_W'(miso));
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        lsb_d     = lsb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETUP;
                    tcnt_d    = '0;
                    bit_cnt_d = '0;
                    tx_d      = tx_data;
                    rx_d      = '0;
                    lsb_d     = lsb_start;
                    mosi_d    = lsb_start ? tx_data[0] : tx_data[DATA_W-1];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    if (tcnt_q == SETUP_LAST) begin
                        tcnt_d  = '0;
                        state_d = SHIFT;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            SHIFT: begin
                // Sample on the rising toggle, launch the next bit on the falling toggle.
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = rx_shift;
                    end else begin
                        tx_d      = tx_shift;
                        mosi_d    = lsb_q ? tx_shift[0] : tx_shift[DATA_W-1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (tcnt_q == HOLD_LAST) begin
                        tcnt_d    = '0;
                        state_d   = IDLE;
                        cs_n_d    = 1'b1;
                        rx_data_d = rx_q;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        mosi_d    = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            tcnt_q    <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            lsb_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            tcnt_q    <= tcnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            lsb_q     <= lsb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl at default parameters; the LSB-first scenario builds only with SPI_LSB_FIRST_EN.
module tb_spi_xfer_ctrl;

    logic       clkin   = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       loopEn  = 1'b0;
    logic       misoFix = 1'b0;
    logic       miso;
    logic       busy, done, sclk, cs_n, mosi;
    logic [7:0] rx_data;
`ifdef SPI_LSB_FIRST_EN
    logic       lsb_first = 1'b0;
`endif

    int passCount  = 0;
    int checkCount = 0;

    int         lat, rises;
    logic [7:0] bits;
    logic       mosiOr;

    assign miso = loopEn ? mosi : misoFix;

    always #5 clkin = ~clkin;

    spi_xfer_ctrl dut (
        .clkin     (clkin),
        .reset     (reset),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .start     (start),
        .tx_data   (tx_data),
        .miso      (miso),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Presents a request that the next rising edge (edge 0) accepts; returns 1 time unit after that edge.
    task automatic applyStimulus(input logic [7:0] tx, input bit holdStart);
        @(negedge clkin);
        tx_data = tx;
        start   = 1'b1;
        @(posedge clkin);
        #1;
        if (!holdStart) start = 1'b0;
    endtask

    // Follows a transfer edge by edge until done; lat stays -1 if done never shows within the budget.
    task automatic watch(input int maxCyc, input int injectAt, output int latOut,
                         output int risesOut, output logic [7:0] bitsOut, output logic mosiOrOut);
        logic prevSclk;
        latOut    = -1;
        risesOut  = 0;
        bitsOut   = 8'h00;
        mosiOrOut = 1'b0;
        prevSclk  = sclk;
        for (int cyc = 1; cyc <= maxCyc; cyc++) begin
            @(posedge clkin);
            #1;
            if (sclk && !prevSclk) begin
                risesOut++;
                bitsOut = {bitsOut[6:0], mosi};
            end
            prevSclk  = sclk;
            mosiOrOut = mosiOrOut | mosi;
            if (cyc == injectAt) begin
                tx_data = 8'h3C;
                start   = 1'b1;
            end
            if (cyc == injectAt + 1) start = 1'b0;
            if (done) begin
                latOut = cyc;
                break;
            end
        end
    endtask

    initial begin
        #12;
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_rx",   32'(rx_data), 32'h0);
        checkOutput("rst_sclk", 32'(sclk), 32'h0);
        checkOutput("rst_cs_n", 32'(cs_n), 32'h1);
        checkOutput("rst_mosi", 32'(mosi), 32'h0);
        @(negedge clkin);
        reset = 1'b0;

        // Loopback 0xA5, MSB first
        loopEn = 1'b1;
        applyStimulus(8'hA5, 1'b0);
        checkOutput("a5_busy_start", 32'(busy), 32'h1);
        checkOutput("a5_cs_start",   32'(cs_n), 32'h0);
        checkOutput("a5_mosi_first", 32'(mosi), 32'h1);
        watch(300, -1, lat, rises, bits, mosiOr);
        checkOutput("a5_latency", 32'(lat), 32'd100);
        checkOutput("a5_rises",   32'(rises), 32'd8);
        checkOutput("a5_mosi_seq", 32'(bits), 32'hA5);
        checkOutput("a5_rx",      32'(rx_data), 32'hA5);
        checkOutput("a5_busy_done", 32'(busy), 32'h0);
        checkOutput("a5_cs_done", 32'(cs_n), 32'h1);

        // Reset while idle clears the held rx_data at once
        @(posedge clkin);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("idle_rst_rx",   32'(rx_data), 32'h0);
        checkOutput("idle_rst_cs_n", 32'(cs_n), 32'h1);
        checkOutput("idle_rst_busy", 32'(busy), 32'h0);
        @(negedge clkin);
        reset = 1'b0;

        // miso tied high, tx zero
        loopEn  = 1'b0;
        misoFix = 1'b1;
        applyStimulus(8'h00, 1'b0);
        watch(300, -1, lat, rises, bits, mosiOr);
        checkOutput("ones_latency", 32'(lat), 32'd100);
        checkOutput("ones_mosi_low", 32'(mosiOr), 32'h0);
        checkOutput("ones_rx",    32'(rx_data), 32'hFF);
        checkOutput("ones_busy",  32'(busy), 32'h0);

        // A second start mid-transfer is ignored
        loopEn = 1'b1;
        applyStimulus(8'h81, 1'b0);
        watch(300, 30, lat, rises, bits, mosiOr);
        checkOutput("inj_latency", 32'(lat), 32'd100);
        checkOutput("inj_rx",      32'(rx_data), 32'h81);
        watch(20, -1, lat, rises, bits, mosiOr);
        checkOutput("inj_no_second_done", 32'(lat), 32'hFFFF_FFFF);

        // Reset at edge 40 aborts, then a clean transfer of 0x3C
        applyStimulus(8'h96, 1'b0);
        repeat (40) @(posedge clkin);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_cs_n", 32'(cs_n), 32'h1);
        checkOutput("abort_sclk", 32'(sclk), 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_rx",   32'(rx_data), 32'h0);
        checkOutput("abort_mosi", 32'(mosi), 32'h0);
        checkOutput("abort_done", 32'(done), 32'h0);
        @(negedge clkin);
        reset = 1'b0;
        watch(150, -1, lat, rises, bits, mosiOr);
        checkOutput("abort_no_done", 32'(lat), 32'hFFFF_FFFF);
        applyStimulus(8'h3C, 1'b0);
        watch(300, -1, lat, rises, bits, mosiOr);
        checkOutput("after_abort_latency", 32'(lat), 32'd100);
        checkOutput("after_abort_rx", 32'(rx_data), 32'h3C);

        // Start held high across done gives a one-cycle cs_n gap
        applyStimulus(8'h55, 1'b1);
        watch(300, -1, lat, rises, bits, mosiOr);
        checkOutput("b2b_latency1", 32'(lat), 32'd100);
        checkOutput("b2b_gap_cs_n", 32'(cs_n), 32'h1);
        checkOutput("b2b_gap_busy", 32'(busy), 32'h0);
        @(posedge clkin);
        #1;
        start = 1'b0;
        checkOutput("b2b_restart_cs_n", 32'(cs_n), 32'h0);
        checkOutput("b2b_restart_busy", 32'(busy), 32'h1);
        watch(300, -1, lat, rises, bits, mosiOr);
        checkOutput("b2b_latency2", 32'(lat), 32'd100);
        checkOutput("b2b_rx", 32'(rx_data), 32'h55);

`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b1;
        applyStimulus(8'h01, 1'b1);
        checkOutput("lsb_mosi_first", 32'(mosi), 32'h1);
        watch(300, -1, lat, rises, bits, mosiOr);
        checkOutput("lsb_latency", 32'(lat), 32'd100);
        checkOutput("lsb_mosi_seq", 32'(bits), 32'h80);
        checkOutput("lsb_rx", 32'(rx_data), 32'h01);
        checkOutput("lsb_gap_cs_n", 32'(cs_n), 32'h1);
        @(posedge clkin);
        #1;
        start = 1'b0;
        checkOutput("lsb_restart_cs_n", 32'(cs_n), 32'h0);
        watch(300, -1, lat, rises, bits, mosiOr);
        checkOutput("lsb_rx2", 32'(rx_data), 32'h01);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
